mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Synthesizable memory-side responder for the hart's instruction and data memory ports.
- Serves instruction fetch and data load/store with 1-cycle registered read latency and byte-masked little-endian writes.
- Adds a small MMIO region: a console TX byte FIFO with a valid/ready drain port, a status word, and a free-running cycle counter.
- Replaces behavioural bench memories so FPGA/synthesis builds run the same programs.

Parameters:
- DEPTH, 1024: storage words; byte range 0 .. 4*DEPTH-1.
- MMIO_BASE, 32'h8000_0000: base of the 16-byte MMIO window.
- FIFO_DEPTH, 4: console FIFO entries; must be a power of two, >= 2.
- INIT_FILE, "program.mem": hex init file, one 32-bit word per line (used only with MEM_INIT_EN).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_imem_raddr  in  32  fetch byte address.
- o_imem_rdata  out  32  fetch word, registered.
- i_dmem_addr  in  32  data byte address.
- i_dmem_ren  in  1  load request.
- i_dmem_wen  in  1  store request.
- i_dmem_wdata  in  32  store data, lane-aligned.
- i_dmem_mask  in  4  byte enables; bit n = wdata[8n+7:8n].
- o_dmem_rdata  out  32  load data, registered.
- o_dmem_fault  out  1  1-cycle pulse on unmapped access; aligned with o_dmem_rdata.
- o_con_valid  out  1  console FIFO non-empty.
- o_con_data  out  8  FIFO head byte.
- i_con_ready  in  1  sink accepts head when high with o_con_valid.

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous and active-high: i_clk, i_rst.
  - Reset values: o_imem_rdata=0, o_dmem_rdata=0, o_dmem_fault=0, FIFO empty (o_con_valid=0, o_con_data=0), overflow flag=0, cycle counter=0.
  - Storage contents are not reset.
  - Reset asserted mid-operation discards queued console bytes. A store presented in the same cycle as reset is not performed.
- Addressing:
  - addr[1:0] is ignored; word index is addr[31:2]. Alignment is the hart's responsibility.
  - Storage hit: addr < 4*DEPTH.
  - MMIO hit: MMIO_BASE <= addr < MMIO_BASE+16.
  - Anything else is unmapped.
- Fetch: o_imem_rdata <= mem[i_imem_raddr[31:2]] every cycle. Out-of-range fetch returns 0 and does not fault.
- Load:
  - Latency 1: data is presented the cycle after i_dmem_ren.
  - o_dmem_rdata is the full word; the mask is ignored on reads.
  - When i_dmem_ren=0, o_dmem_rdata <= 0 on the next edge.
- Store:
  - Performed at the edge where i_dmem_wen=1; only lanes with mask bit set are written.
  - mask=0 is a no-op.
- Same-cycle hazards:
  - Read-before-write: a load or fetch of the word being stored in the same cycle returns the old contents.
  - ren and wen may both be high. The store is performed and the load returns old data.
- MMIO map (offset from MMIO_BASE):
  - 0x0 CONSOLE:
    - Store with mask[0]=1 pushes wdata[7:0]; other lanes are ignored.
    - Push while full is dropped and sets the sticky overflow flag.
    - Push and pop in the same cycle while full: the push is accepted and the count is unchanged.
    - Load returns 0.
  - 0x4 STATUS: load returns {29'b0, overflow, full, empty}. A store with mask[0]=1 and wdata[2]=1 clears overflow.
  - 0x8 CYCLE: load returns the 32-bit cycle counter. It increments every non-reset cycle and wraps 0xFFFF_FFFF -> 0. Stores are ignored.
  - 0xC: reserved; reads 0, stores ignored, no fault.
- Unmapped access: any ren or wen to an unmapped address gives o_dmem_fault=1 next cycle and o_dmem_rdata=0. Stores have no effect.
- Console FIFO:
  - Pop occurs when o_con_valid && i_con_ready.
  - A push into an empty FIFO makes o_con_valid=1 on the next cycle; there is no bypass.
  - o_con_data must hold steady while valid && !ready.
  - Pointers wrap modulo FIFO_DEPTH. full and empty are derived from an extra pointer bit.

Optional Feature:
- MEM_INIT_EN defined: storage is initialised at elaboration via $readmemh(INIT_FILE) (word-per-line); words beyond the file remain unset.
- MEM_INIT_EN undefined: no initial block; contents are X in simulation until written.

Test Plan:
- Store word 0x1122_3344 to 0x10 with mask 1111, then store 0xAABB_CCDD with mask 0101 to 0x10, then load 0x10 -> rdata 0x11BB_33DD one cycle after ren; rdata 0 the following cycle with ren=0.
- Load and store 0xDEAD_BEEF (mask 1111) to 0x20 in the same cycle, old contents 0 -> that load returns 0; next load returns 0xDEAD_BEEF. Fetch of 0x20 in the store cycle also returns old data.
- Hold i_con_ready=0 and push bytes 0x41..0x45 to MMIO_BASE -> first 4 queued. STATUS reads 0x6 (overflow=1, full=1). Raise ready -> drains 0x41,0x42,0x43,0x44 on 4 consecutive cycles, then valid=0 and STATUS=0x5. Store 0x4 to STATUS -> STATUS=0x1.
- With the FIFO full and ready=1, push 0x50 in the same cycle as a pop -> accepted; the sequence continues and 0x50 is delivered last; overflow is not set.
- Load from 0x0001_0000 (unmapped, DEPTH=1024) -> o_dmem_fault=1 for exactly 1 cycle, rdata 0. Store there -> fault, and no storage word changes.
- Read CYCLE twice, 10 cycles apart -> difference 10. Assert i_rst mid-drain with 3 bytes queued -> next cycle o_con_valid=0, CYCLE reads 1 on the first load after reset release.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder: instruction fetch, data load/store and a small MMIO window.
// Latency: fetch and load data, and the fault pulse, appear one cycle after the request. Stores take effect at the request edge.
// Backpressure: none on the memory ports. The console drains by valid/ready. A push while the FIFO is full is dropped and sets a sticky flag.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_imem_raddr / o_imem_rdata   fetch byte address / registered fetch word
//   i_dmem_*                      load/store request (addr, ren, wen, wdata, byte mask)
//   o_dmem_rdata / o_dmem_fault   registered load data / one-cycle unmapped-access pulse
//   o_con_valid/o_con_data/i_con_ready  console TX byte drain port
//
// MMIO map (offset from MMIO_BASE):
//   0x0 CONSOLE push    0x4 STATUS {overflow,full,empty}    0x8 CYCLE    0xC reserved

module mem_responder #(
  parameter int unsigned DEPTH      = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter              INIT_FILE  = "program.mem"
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_imem_raddr,
  output logic [31:0] o_imem_rdata,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic [31:0] o_dmem_rdata,
  output logic        o_dmem_fault,
  output logic        o_con_valid,
  output logic [7:0]  o_con_data,
  input  logic        i_con_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  localparam logic [1:0] REG_CONSOLE = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CYCLE   = 2'd2;

  // ---------------------------------------------------------------- storage
  logic [31:0] mem [0:DEPTH-1];

  logic unused_init;
  assign unused_init = ^INIT_FILE;

  // Byte offset bits are ignored on both ports; alignment belongs to the hart.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_imem_raddr[1:0], i_dmem_addr[1:0]};

  // ------------------------------------------------------------- decoding
  // Range checks use the full word index so that high addresses never alias
  // onto low storage words through the truncated index.
  logic [29:0]   d_word, i_word;
  logic [AW-1:0] d_idx, i_idx;
  logic          d_store_hit, i_store_hit;
  logic [31:0]   mmio_off;
  logic          mmio_hit;
  logic [1:0]    mmio_reg;
  logic          d_unmapped;

  assign d_word      = i_dmem_addr[31:2];
  assign i_word      = i_imem_raddr[31:2];
  assign d_idx       = d_word[AW-1:0];
  assign i_idx       = i_word[AW-1:0];
  assign d_store_hit = (d_word < 30'(DEPTH));
  assign i_store_hit = (i_word < 30'(DEPTH));

  // Unsigned subtraction makes addresses below the base wrap to huge offsets,
  // so one compare covers both window edges.
  assign mmio_off   = i_dmem_addr - MMIO_BASE;
  assign mmio_hit   = (mmio_off < 32'd16);
  assign mmio_reg   = mmio_off[3:2];
  assign d_unmapped = !d_store_hit && !mmio_hit;

  // ------------------------------------------------------- console FIFO
  logic [7:0] fifo_mem [0:FIFO_DEPTH-1];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic        overflow;
  logic        push_req, push_ok, pop, status_clr;
  logic [31:0] cycle_cnt;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign pop        = o_con_valid && i_con_ready;
  assign push_req   = !i_rst && i_dmem_wen && mmio_hit &&
                      (mmio_reg == REG_CONSOLE) && i_dmem_mask[0];
  // A pop in the same cycle frees the head slot, so a push into a full FIFO
  // is still accepted then.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign status_clr = !i_rst && i_dmem_wen && mmio_hit &&
                      (mmio_reg == REG_STATUS) && i_dmem_mask[0] && i_dmem_wdata[2];

  assign o_con_valid = !fifo_empty;
  assign o_con_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[PW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      cycle_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      if (push_req && !push_ok) overflow <= 1'b1;
      else if (status_clr)      overflow <= 1'b0;
    end
  end

  // The FIFO storage has no reset; the pointers alone define its contents.
  always_ff @(posedge i_clk) begin
    if (push_ok) fifo_mem[wr_ptr[PW-1:0]] <= i_dmem_wdata[7:0];
  end

  // ------------------------------------------------------ storage writes
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_dmem_wen && d_store_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (i_dmem_mask[b]) mem[d_idx][8*b +: 8] <= i_dmem_wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------- load data
  logic [31:0] load_data;

  always_comb begin
    load_data = 32'd0;
    if (d_store_hit) begin
      load_data = mem[d_idx];
    end else if (mmio_hit) begin
      case (mmio_reg)
        REG_STATUS: load_data = {29'd0, overflow, fifo_full, fifo_empty};
        REG_CYCLE:  load_data = cycle_cnt;
        default:    load_data = 32'd0;
      endcase
    end
  end

  // Reads sample pre-edge contents, so a same-cycle store is seen only by
  // the following access.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_imem_rdata <= 32'd0;
      o_dmem_rdata <= 32'd0;
      o_dmem_fault <= 1'b0;
    end else begin
      o_imem_rdata <= i_store_hit ? mem[i_idx] : 32'd0;
      o_dmem_rdata <= i_dmem_ren ? load_data : 32'd0;
      o_dmem_fault <= (i_dmem_ren || i_dmem_wen) && d_unmapped;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table for storage/decode, hand sequences for console FIFO, cycle counter and reset.
module tb_mem_responder;

  localparam logic [31:0] MB  = 32'h8000_0000;
  localparam logic [31:0] OOR = 32'h0001_0000;

  logic        clk;
  logic        rst;
  logic [31:0] imem_raddr;
  logic [31:0] imem_rdata;
  logic [31:0] dmem_addr;
  logic        dmem_ren;
  logic        dmem_wen;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mask;
  logic [31:0] dmem_rdata;
  logic        dmem_fault;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;

  int n_tests = 0;
  int n_fail  = 0;

  mem_responder dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_imem_raddr (imem_raddr),
    .o_imem_rdata (imem_rdata),
    .i_dmem_addr  (dmem_addr),
    .i_dmem_ren   (dmem_ren),
    .i_dmem_wen   (dmem_wen),
    .i_dmem_wdata (dmem_wdata),
    .i_dmem_mask  (dmem_mask),
    .o_dmem_rdata (dmem_rdata),
    .o_dmem_fault (dmem_fault),
    .o_con_valid  (con_valid),
    .o_con_data   (con_data),
    .i_con_ready  (con_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] iaddr;
    logic [31:0] exp_im;
    logic [31:0] exp_rd;
    logic        exp_flt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ren, logic wen, logic [31:0] addr,
                              logic [31:0] wdata, logic [3:0] mask,
                              logic [31:0] iaddr, logic [31:0] exp_im,
                              logic [31:0] exp_rd, logic exp_flt);
    vec_t v;
    v.ren = ren; v.wen = wen; v.addr = addr; v.wdata = wdata; v.mask = mask;
    v.iaddr = iaddr; v.exp_im = exp_im; v.exp_rd = exp_rd; v.exp_flt = exp_flt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask);
    dmem_ren = ren; dmem_wen = wen; dmem_addr = addr;
    dmem_wdata = wdata; dmem_mask = mask;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    drive(1'b0, 1'b1, MB, {24'd0, b}, 4'b0001);
    step();
    idle();
  endtask

  task automatic load_chk(input string nm, input logic [31:0] addr, input logic [31:0] exp);
    drive(1'b1, 1'b0, addr, 32'd0, 4'd0);
    step();
    idle();
    chk(nm, dmem_rdata, exp);
  endtask

  logic [31:0] c1, c2;
  logic [7:0]  seqb [5];

  initial begin
    rst = 1'b1;
    con_ready = 1'b0;
    imem_raddr = OOR;
    idle();

    // Storage, decode and boundary vectors (iaddr OOR => fetch 0)
    vecs.push_back(mk(0,1,32'h0000_0000,32'h1234_5678,4'hF, OOR,32'h0,        32'h0,        0));
    vecs.push_back(mk(0,1,32'h0000_0010,32'h1122_3344,4'hF, OOR,32'h0,        32'h0,        0));
    vecs.push_back(mk(0,1,32'h0000_0010,32'hAABB_CCDD,4'h5, OOR,32'h0,        32'h0,        0));
    vecs.push_back(mk(1,0,32'h0000_0010,32'h0,        4'h0, 32'h10,32'h11BB_33DD,32'h11BB_33DD,0));
    vecs.push_back(mk(0,0,32'h0,        32'h0,        4'h0, 32'h0, 32'h1234_5678,32'h0,        0));
    vecs.push_back(mk(0,1,32'h0000_0020,32'h0,        4'hF, OOR,32'h0,        32'h0,        0));
    vecs.push_back(mk(1,1,32'h0000_0020,32'hDEAD_BEEF,4'hF, 32'h20,32'h0,        32'h0,        0));
    vecs.push_back(mk(1,0,32'h0000_0020,32'h0,        4'h0, 32'h20,32'hDEAD_BEEF,32'hDEAD_BEEF,0));
    vecs.push_back(mk(0,1,32'h0000_0020,32'h9900_0000,4'h8, OOR,32'h0,        32'h0,        0));
    vecs.push_back(mk(0,1,32'h0000_0020,32'hFFFF_FFFF,4'h0, OOR,32'h0,        32'h0,        0));
    vecs.push_back(mk(1,0,32'h0000_0020,32'h0,        4'h0, 32'h20,32'h99AD_BEEF,32'h99AD_BEEF,0));
    vecs.push_back(mk(0,1,32'h0000_0FFC,32'hCAFE_F00D,4'hF, OOR,32'h0,        32'h0,        0));
    vecs.push_back(mk(1,0,32'h0000_0FFC,32'h0,        4'h0, 32'hFFC,32'hCAFE_F00D,32'hCAFE_F00D,0));
    vecs.push_back(mk(1,0,32'h0000_1000,32'h0,        4'h0, 32'h1000,32'h0,      32'h0,        1));
    vecs.push_back(mk(0,0,32'h0,        32'h0,        4'h0, OOR,32'h0,        32'h0,        0));
    vecs.push_back(mk(1,0,OOR,          32'h0,        4'h0, OOR,32'h0,        32'h0,        1));
    vecs.push_back(mk(0,1,OOR,          32'hFFFF_FFFF,4'hF, OOR,32'h0,        32'h0,        1));
    vecs.push_back(mk(1,0,32'h0000_0000,32'h0,        4'h0, OOR,32'h0,        32'h1234_5678,0));
    vecs.push_back(mk(1,0,32'h7FFF_FFFC,32'h0,        4'h0, OOR,32'h0,        32'h0,        1));
    vecs.push_back(mk(1,0,MB + 32'h10,  32'h0,        4'h0, OOR,32'h0,        32'h0,        1));
    vecs.push_back(mk(1,0,MB + 32'hC,   32'h0,        4'h0, OOR,32'h0,        32'h0,        0));
    vecs.push_back(mk(0,1,MB + 32'hC,   32'h1234,     4'hF, OOR,32'h0,        32'h0,        0));
    vecs.push_back(mk(0,1,MB + 32'h8,   32'hFFFF,     4'hF, OOR,32'h0,        32'h0,        0));
    vecs.push_back(mk(0,1,MB,           32'h0000_0041,4'hE, OOR,32'h0,        32'h0,        0));
    vecs.push_back(mk(1,0,MB,           32'h0,        4'h0, OOR,32'h0,        32'h0,        0));
    vecs.push_back(mk(1,0,MB + 32'h4,   32'h0,        4'h0, OOR,32'h0,        32'h1,        0));

    // Reset state
    repeat (3) step();
    chk("rst.imem_rdata", imem_rdata, 32'd0);
    chk("rst.dmem_rdata", dmem_rdata, 32'd0);
    chk("rst.dmem_fault", {31'd0, dmem_fault}, 32'd0);
    chk("rst.con_valid", {31'd0, con_valid}, 32'd0);
    chk("rst.con_data", {24'd0, con_data}, 32'd0);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].mask);
      imem_raddr = vecs[i].iaddr;
      step();
      chk($sformatf("v%0d.rdata", i), dmem_rdata, vecs[i].exp_rd);
      chk($sformatf("v%0d.fault", i), {31'd0, dmem_fault}, {31'd0, vecs[i].exp_flt});
      chk($sformatf("v%0d.imem", i), imem_rdata, vecs[i].exp_im);
    end
    idle();
    imem_raddr = OOR;
    step();

    // Console: fill, overflow, drain, clear overflow
    con_ready = 1'b0;
    push(8'h41);
    chk("con.valid_after_first_push", {31'd0, con_valid}, 32'd1);
    push(8'h42); push(8'h43); push(8'h44); push(8'h45);
    load_chk("con.status_full_ovf", MB + 32'h4, 32'h6);
    chk("con.head_held", {24'd0, con_data}, 32'h41);
    con_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("con.drain%0d_valid", i), {31'd0, con_valid}, 32'd1);
      chk($sformatf("con.drain%0d_data", i), {24'd0, con_data}, 32'h41 + i);
      step();
    end
    chk("con.valid_after_drain", {31'd0, con_valid}, 32'd0);
    load_chk("con.status_empty_ovf", MB + 32'h4, 32'h5);
    drive(1'b0, 1'b1, MB + 32'h4, 32'h4, 4'b0001);
    step();
    idle();
    load_chk("con.status_cleared", MB + 32'h4, 32'h1);

    // Console: push while full in the same cycle as a pop
    con_ready = 1'b0;
    push(8'h60); push(8'h61); push(8'h62); push(8'h63);
    seqb = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h50};
    con_ready = 1'b1;
    drive(1'b0, 1'b1, MB, 32'h50, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("popush%0d_valid", i), {31'd0, con_valid}, 32'd1);
      chk($sformatf("popush%0d_data", i), {24'd0, con_data}, {24'd0, seqb[i]});
      step();
      idle();
    end
    chk("popush.valid_end", {31'd0, con_valid}, 32'd0);
    con_ready = 1'b0;
    load_chk("popush.status", MB + 32'h4, 32'h1);

    // Cycle counter: two reads 10 cycles apart
    drive(1'b1, 1'b0, MB + 32'h8, 32'd0, 4'd0);
    step();
    idle();
    c1 = dmem_rdata;
    repeat (9) step();
    drive(1'b1, 1'b0, MB + 32'h8, 32'd0, 4'd0);
    step();
    idle();
    c2 = dmem_rdata;
    chk("cycle.delta", c2 - c1, 32'd10);

    // Reset mid-drain with 3 bytes queued; store and push in the reset cycle are dropped
    push(8'h70); push(8'h71); push(8'h72); push(8'h73);
    con_ready = 1'b1;
    step();
    chk("rstmid.head", {24'd0, con_data}, 32'h71);
    rst = 1'b1;
    drive(1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF);
    step();
    chk("rstmid.valid", {31'd0, con_valid}, 32'd0);
    chk("rstmid.data", {24'd0, con_data}, 32'd0);
    rst = 1'b0;
    con_ready = 1'b0;
    idle();
    step();
    load_chk("rstmid.cycle_first_load", MB + 32'h8, 32'd1);
    load_chk("rstmid.store_dropped", 32'h10, 32'h11BB_33DD);
    load_chk("rstmid.status", MB + 32'h4, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
